pipelined_cpu_core: RTL and testbench
=====================================

# pipelined_cpu_core

Parametrised five-stage (IF/ID/EX/MEM/WB) integer core, successor to the fixed 32-bit pipelined CPU. Adds:
- generic data and address widths;
- a single three-operand register file with r0 hardwired to zero;
- full EX forwarding, a one-cycle load-use interlock and branch flush;
- borrow-aware carry and a retire strobe.

It connects to a synchronous instruction memory and a synchronous data memory.

## Interface
- DATA_W, 32, datapath/register width (≥16)
- ADDR_W, 11, instruction/data address width (≤13)
- NREGS, 32, register count, power of two, ≤32
- RESET_PC, 0, fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_re  out  1  instruction read enable; memory holds imem_rdata when low
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_rdata  in  32  instruction, valid one cycle after imem_re
- dmem_re / dmem_we  out  1  data read / write enable (MEM stage)
- dmem_addr  out  ADDR_W  data address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, one cycle after dmem_re
- retire  out  1  pulse per instruction completing WB (NOP included, bubbles excluded)
- result  out  DATA_W  last WB value (ALU result or load data; unchanged by STORE/BRANCH/NOP)
- flags  out  4  {C,N,Z,P}
- stall  out  1  load-use interlock active this cycle

## Operation

**Encoding**
- [31:29] opcode: 111 LOAD, 110 STORE, 101 BRANCH, 100 ADD, 011 SUB, 010 AND, 001 OR, 000 NOP.
- [28:24] rd, [23:19] rs1, [18:14] rs2, [13] imm_sel, [12:0] imm13.
- imm13 is zero-extended to DATA_W.
- Register indices use the low log2(NREGS) bits.

**ALU ops**
- Operation is rd ← rs1 op op2, where op2 = imm_sel ? imm13 : rs2.
- ADD: C = carry-out.
- SUB: C = borrow (rs1 < op2 unsigned).
- AND/OR: C = 0.
- N = msb, Z = result==0, P = XOR-reduce (1 = odd).
- Flags update only on ALU ops, registered at end of EX.

**Memory ops**
- LOAD: rd ← mem[addr]. STORE: mem[addr] ← rs2.
- addr = imm_sel ? imm13[ADDR_W-1:0] : rs1[ADDR_W-1:0].

**BRANCH**
- cond is [28:26]: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 N, 110 !N, 111 P.
- target = [ADDR_W-1:0].
- Resolved in EX against the flags register, which already includes the immediately preceding ALU op.

**Register file**
- Reads of r0 return 0; writes to r0 are dropped.
- Same-cycle WB write is visible to the ID read (write-through).
- All registers clear on reset.

**Forwarding into EX** (both operands and store data)
- Priority: EX/MEM ALU result, then WB value (ALU result or dmem_rdata), then register file.

**Load-use interlock**
- Triggered when an instruction in ID reads the rd of a LOAD in EX.
- Response: hold PC and ID, imem_re=0, inject a bubble into EX, stall=1 for exactly one cycle.
- Load data is then forwarded from WB.

**Taken branch**
- PC ← target.
- ID instruction and the in-flight fetch are squashed (valid cleared).
- Penalty is 2 cycles; a not-taken branch has no penalty.

**Reset (any cycle, including mid-stall or mid-branch)**
- PC=RESET_PC and all stage valids clear.
- Outputs during reset: imem_re=0, dmem_re=dmem_we=0, retire=0, stall=0, result=0, flags=0, imem_addr=RESET_PC.

## Timing
- Fetch at cycle 0 retires with retire=1 at cycle 4 (WB).
- Throughput is 1 instruction/cycle absent stalls and flushes.
- dmem_* signals are driven from registers (MEM stage).
- A STORE in cycle t followed by a LOAD of the same address in cycle t+1 returns the new data; this relies on a write-then-read memory.
- A taken branch in EX at cycle t puts imem_addr=target at t+1; the target retires at t+5.
- A simultaneous stall request and taken branch: the branch wins, the stall is cancelled and the ID instruction is squashed.
- PC wraps modulo 2^ADDR_W.

## Structure
- cpu_pkg holds: opcode and branch-condition constants, instruction field positions, and the flag bit indices (C=3, N=2, Z=1, P=0).
- Sub-module cpu_regfile (NREGS×DATA_W, 2 read / 1 write, r0 zero, write-through).
- Hazard, forwarding and ALU logic stay in pipelined_cpu_core.

## Test plan
- **Forwarding:** after reset, ADD r1,r0,#5 then ADD r2,r1,#7 back-to-back → no stall, r2=12, result=12 on consecutive retire cycles.
- **Load-use:** dmem[3]=0xDEADBEEF; LOAD r3,#3 then ADD r4,r3,#1 → stall=1 for exactly one cycle, r4=0xDEADBEF0.
- **Branch:**
  - SUB r5,r1,r1 (Z=1) then BRANCH Z to 0x020 → the two following fetches never retire; next retire is from 0x020.
  - BRANCH !Z → no bubble.
- **Flags:**
  - ADD 0xFFFFFFFF + #1 → result=0, flags C=1,N=0,Z=1,P=0.
  - SUB r0 − #1 → 0xFFFFFFFF, C=1,N=1,Z=0,P=0.
- **Store/load:** STORE r2,#0x10 then LOAD r6,#0x10 → dmem_we=1 with dmem_addr=0x010, dmem_wdata=12; then r6=12.
- **Reset mid-operation:** reset asserted during a load-use stall → next cycle imem_addr=RESET_PC, no retire for 4 cycles after release, reads of r1–r31 return 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the five-stage integer core: opcodes, branch
// conditions, instruction field positions and flag bit indices.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_OR     = 3'b001,
    OP_AND    = 3'b010,
    OP_SUB    = 3'b011,
    OP_ADD    = 3'b100,
    OP_BRANCH = 3'b101,
    OP_STORE  = 3'b110,
    OP_LOAD   = 3'b111
  } opcode_t;

  // Branch conditions live in instruction bits [28:26]
  localparam logic [2:0] BC_ALWAYS = 3'b000;
  localparam logic [2:0] BC_Z      = 3'b001;
  localparam logic [2:0] BC_NZ     = 3'b010;
  localparam logic [2:0] BC_C      = 3'b011;
  localparam logic [2:0] BC_NC     = 3'b100;
  localparam logic [2:0] BC_N      = 3'b101;
  localparam logic [2:0] BC_NN     = 3'b110;
  localparam logic [2:0] BC_P      = 3'b111;

  // Instruction field positions (LSB of each field)
  localparam int OP_LSB   = 29;
  localparam int RD_LSB   = 24;
  localparam int COND_LSB = 26;
  localparam int RS1_LSB  = 19;
  localparam int RS2_LSB  = 14;
  localparam int ISEL_BIT = 13;
  localparam int IMM_W    = 13;

  // Flag vector {C,N,Z,P}
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_P = 0;

  function automatic logic is_alu(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // rs1 feeds every ALU op, and memory ops when addressing by register
  function automatic logic uses_rs1(input opcode_t op, input logic isel);
    if (is_alu(op)) return 1'b1;
    if (op == OP_LOAD || op == OP_STORE) return !isel;
    return 1'b0;
  endfunction

  // rs2 feeds register-form ALU ops and is always the store data
  function automatic logic uses_rs2(input opcode_t op, input logic isel);
    if (is_alu(op)) return !isel;
    return op == OP_STORE;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// NREGS x DATA_W register file, two read ports and one write port.
// r0 reads as zero; a write in the same cycle is visible on the read ports.
module cpu_regfile import cpu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NREGS];

  // Storage: clear everything on reset, drop writes aimed at r0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports with write-through bypass
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/pipelined_cpu_core.sv
// Five-stage IF/ID/EX/MEM/WB integer core. The ID instruction is the
// synchronous imem output itself (held by dropping imem_re), EX forwards
// from MEM and WB, a LOAD in EX interlocks a dependent ID instruction for
// one cycle, and a taken branch in EX squashes ID and the in-flight fetch.
module pipelined_cpu_core import cpu_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 11,
  parameter int NREGS    = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_re,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retire,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              stall
);

  localparam int RW = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  // IF / ID
  logic [ADDR_W-1:0] pc;
  logic              id_vld;
  opcode_t           id_op;
  logic              id_isel;
  logic [RW-1:0]     id_rs1, id_rs2;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic              load_use, stall_int;

  // EX
  logic              ex_vld;
  logic [31:0]       ex_ir;
  logic [DATA_W-1:0] ex_rv1, ex_rv2;
  opcode_t           ex_op;
  logic [RW-1:0]     ex_rd, ex_rs1, ex_rs2;
  logic              ex_isel;
  logic [DATA_W-1:0] ex_imm, ex_a, ex_b, ex_op2, alu_res;
  logic              alu_c, cond_ok, take;
  logic [ADDR_W-1:0] ex_maddr;
  logic [3:0]        flags_q;

  // MEM
  logic              mem_vld, mem_alu, mem_load, mem_store, mem_fwd;
  logic [RW-1:0]     mem_rd;
  logic [DATA_W-1:0] mem_res, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  // WB
  logic              wb_vld, wb_alu, wb_load, wb_fwd, wb_has_res;
  logic [RW-1:0]     wb_rd;
  logic [DATA_W-1:0] wb_res, wb_val, result_q;

  assign id_op   = opcode_t'(imem_rdata[OP_LSB +: 3]);
  assign id_isel = imem_rdata[ISEL_BIT];
  assign id_rs1  = imem_rdata[RS1_LSB +: RW];
  assign id_rs2  = imem_rdata[RS2_LSB +: RW];

  assign ex_op   = opcode_t'(ex_ir[OP_LSB +: 3]);
  assign ex_rd   = ex_ir[RD_LSB +: RW];
  assign ex_rs1  = ex_ir[RS1_LSB +: RW];
  assign ex_rs2  = ex_ir[RS2_LSB +: RW];
  assign ex_isel = ex_ir[ISEL_BIT];
  assign ex_imm  = DATA_W'(ex_ir[IMM_W-1:0]);

  assign wb_has_res = wb_alu || wb_load;
  assign wb_val     = wb_load ? dmem_rdata : wb_res;
  assign wb_fwd     = wb_vld && wb_has_res && wb_rd != '0;
  // A LOAD sitting in MEM has no data yet; the interlock keeps consumers away
  assign mem_fwd    = mem_vld && mem_alu && mem_rd != '0;

  cpu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(RW)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_fwd),
    .waddr  (wb_rd),
    .wdata  (wb_val),
    .raddr1 (id_rs1),
    .raddr2 (id_rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // Operand forwarding: youngest producer first, then WB, then the register file
  always_comb begin
    ex_a = ex_rv1;
    if (mem_fwd && mem_rd == ex_rs1)     ex_a = mem_res;
    else if (wb_fwd && wb_rd == ex_rs1)  ex_a = wb_val;
    ex_b = ex_rv2;
    if (mem_fwd && mem_rd == ex_rs2)     ex_b = mem_res;
    else if (wb_fwd && wb_rd == ex_rs2)  ex_b = wb_val;
  end

  assign ex_op2   = ex_isel ? ex_imm : ex_b;
  assign ex_maddr = ex_isel ? ex_ir[ADDR_W-1:0] : ex_a[ADDR_W-1:0];

  // ALU; SUB carry is the unsigned borrow
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (ex_op)
      OP_ADD:  {alu_c, alu_res} = {1'b0, ex_a} + {1'b0, ex_op2};
      OP_SUB:  begin alu_res = ex_a - ex_op2; alu_c = ex_a < ex_op2; end
      OP_AND:  alu_res = ex_a & ex_op2;
      OP_OR:   alu_res = ex_a | ex_op2;
      default: ;
    endcase
  end

  // Branch condition against the flags register
  always_comb begin
    cond_ok = 1'b0;
    case (ex_ir[COND_LSB +: 3])
      BC_ALWAYS: cond_ok = 1'b1;
      BC_Z:      cond_ok = flags_q[FLAG_Z];
      BC_NZ:     cond_ok = !flags_q[FLAG_Z];
      BC_C:      cond_ok = flags_q[FLAG_C];
      BC_NC:     cond_ok = !flags_q[FLAG_C];
      BC_N:      cond_ok = flags_q[FLAG_N];
      BC_NN:     cond_ok = !flags_q[FLAG_N];
      BC_P:      cond_ok = flags_q[FLAG_P];
      default:   cond_ok = 1'b0;
    endcase
  end

  assign take = ex_vld && ex_op == OP_BRANCH && cond_ok;

  // Load-use hazard; a taken branch squashes ID so it overrides the stall
  assign load_use = id_vld && ex_vld && ex_op == OP_LOAD && ex_rd != '0 &&
                    ((uses_rs1(id_op, id_isel) && id_rs1 == ex_rd) ||
                     (uses_rs2(id_op, id_isel) && id_rs2 == ex_rd));
  assign stall_int = load_use && !take;

  // Front end: PC, fetch validity and the ID/EX register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= PC0;
      id_vld <= 1'b0;
      ex_vld <= 1'b0;
    end else if (take) begin
      pc     <= ex_ir[ADDR_W-1:0];
      id_vld <= 1'b0;
      ex_vld <= 1'b0;
    end else if (stall_int) begin
      ex_vld <= 1'b0;
    end else begin
      pc     <= pc + ADDR_W'(1);
      id_vld <= 1'b1;
      ex_vld <= id_vld;
      ex_ir  <= imem_rdata;
      ex_rv1 <= rf_rd1;
      ex_rv2 <= rf_rd2;
    end
  end

  // EX/MEM register and the flags, which only ALU ops update
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_vld <= 1'b0;
      flags_q <= '0;
    end else begin
      mem_vld   <= ex_vld;
      mem_alu   <= is_alu(ex_op);
      mem_load  <= ex_op == OP_LOAD;
      mem_store <= ex_op == OP_STORE;
      mem_rd    <= ex_rd;
      mem_res   <= alu_res;
      mem_addr  <= ex_maddr;
      mem_wdata <= ex_b;
      if (ex_vld && is_alu(ex_op)) begin
        flags_q[FLAG_C] <= alu_c;
        flags_q[FLAG_N] <= alu_res[DATA_W-1];
        flags_q[FLAG_Z] <= alu_res == '0;
        flags_q[FLAG_P] <= ^alu_res;
      end
    end
  end

  // MEM/WB register and the sticky last-result register
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_vld   <= 1'b0;
      result_q <= '0;
    end else begin
      wb_vld  <= mem_vld;
      wb_alu  <= mem_alu;
      wb_load <= mem_load;
      wb_rd   <= mem_rd;
      wb_res  <= mem_res;
      if (wb_vld && wb_has_res) result_q <= wb_val;
    end
  end

  assign imem_re    = !reset && !stall_int;
  assign imem_addr  = reset ? PC0 : pc;
  assign dmem_re    = !reset && mem_vld && mem_load;
  assign dmem_we    = !reset && mem_vld && mem_store;
  assign dmem_addr  = mem_addr;
  assign dmem_wdata = mem_wdata;
  assign retire     = !reset && wb_vld;
  assign result     = reset ? '0 : ((wb_vld && wb_has_res) ? wb_val : result_q);
  assign flags      = reset ? 4'h0 : flags_q;
  assign stall      = !reset && stall_int;

endmodule

// File: tb/tb_pipelined_cpu_core.sv
// Directed bench for pipelined_cpu_core: a table of instructions with the
// result/flags expected at each retire, plus hand-written branch and
// reset-during-stall sequences.
module tb_pipelined_cpu_core;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_re;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        dmem_re, dmem_we;
  logic [10:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'h0;
  logic        retire;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        stall;

  logic [31:0] imem [0:2047];
  logic [31:0] dmem [0:2047];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_cpu_core dut (
    .clk        (clk),
    .reset      (reset),
    .imem_re    (imem_re),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_re    (dmem_re),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .retire     (retire),
    .result     (result),
    .flags      (flags),
    .stall      (stall)
  );

  // Synchronous memories; imem holds its output while imem_re is low
  always @(posedge clk) begin
    if (imem_re) imem_rdata <= imem[imem_addr];
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    if (dmem_re) dmem_rdata <= dmem[dmem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic isel, input logic [12:0] imm);
    return {op, rd, rs1, rs2, isel, imm};
  endfunction

  task automatic clear_mems();
    for (int i = 0; i < 2048; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
  endtask

  // Reset for two edges; release just after an edge so the next negedge is cycle 0
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] res;
    logic        fchk;
    logic [3:0]  flg;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  typedef struct {
    int          cyc;
    logic [31:0] res;
  } ret_t;

  initial begin
    int idx, nstall, stall_cyc, first_cyc, last_cyc, sidx, nret, nz;
    ret_t bexp [8];
    ret_t bgot [$];
    logic [10:0] s_addr [2];
    logic [31:0] s_data [2];

    // instruction, result at its retire, check flags?, {C,N,Z,P}
    vt[0]  = '{enc(OP_ADD,   5'd1,  5'd0, 5'd0,  1'b1, 13'd5),    32'd5,        1'b0, 4'b0000};
    vt[1]  = '{enc(OP_ADD,   5'd2,  5'd1, 5'd0,  1'b1, 13'd7),    32'd12,       1'b1, 4'b0000};
    vt[2]  = '{enc(OP_NOP,   5'd0,  5'd0, 5'd0,  1'b0, 13'd0),    32'd12,       1'b0, 4'b0000};
    vt[3]  = '{enc(OP_SUB,   5'd7,  5'd0, 5'd0,  1'b1, 13'd1),    32'hFFFFFFFF, 1'b1, 4'b1100};
    vt[4]  = '{enc(OP_NOP,   5'd0,  5'd0, 5'd0,  1'b0, 13'd0),    32'hFFFFFFFF, 1'b0, 4'b0000};
    vt[5]  = '{enc(OP_ADD,   5'd8,  5'd7, 5'd0,  1'b1, 13'd1),    32'd0,        1'b1, 4'b1010};
    vt[6]  = '{enc(OP_NOP,   5'd0,  5'd0, 5'd0,  1'b0, 13'd0),    32'd0,        1'b0, 4'b0000};
    vt[7]  = '{enc(OP_STORE, 5'd0,  5'd0, 5'd2,  1'b1, 13'h10),   32'd0,        1'b0, 4'b0000};
    vt[8]  = '{enc(OP_LOAD,  5'd6,  5'd0, 5'd0,  1'b1, 13'h10),   32'd12,       1'b0, 4'b0000};
    vt[9]  = '{enc(OP_LOAD,  5'd3,  5'd0, 5'd0,  1'b1, 13'd3),    32'hDEADBEEF, 1'b0, 4'b0000};
    vt[10] = '{enc(OP_ADD,   5'd4,  5'd3, 5'd0,  1'b1, 13'd1),    32'hDEADBEF0, 1'b1, 4'b0101};
    vt[11] = '{enc(OP_NOP,   5'd0,  5'd0, 5'd0,  1'b0, 13'd0),    32'hDEADBEF0, 1'b0, 4'b0000};
    vt[12] = '{enc(OP_AND,   5'd9,  5'd4, 5'd1,  1'b0, 13'd0),    32'd0,        1'b0, 4'b0000};
    vt[13] = '{enc(OP_OR,    5'd10, 5'd4, 5'd2,  1'b0, 13'd0),    32'hDEADBEFC, 1'b0, 4'b0000};
    vt[14] = '{enc(OP_SUB,   5'd11, 5'd2, 5'd10, 1'b0, 13'd0),    32'h21524110, 1'b1, 4'b1000};
    vt[15] = '{enc(OP_NOP,   5'd0,  5'd0, 5'd0,  1'b0, 13'd0),    32'h21524110, 1'b0, 4'b0000};
    vt[16] = '{enc(OP_STORE, 5'd0,  5'd1, 5'd11, 1'b0, 13'd0),    32'h21524110, 1'b0, 4'b0000};
    vt[17] = '{enc(OP_LOAD,  5'd12, 5'd1, 5'd0,  1'b0, 13'd0),    32'h21524110, 1'b0, 4'b0000};
    vt[18] = '{enc(OP_NOP,   5'd0,  5'd0, 5'd0,  1'b0, 13'd0),    32'h21524110, 1'b0, 4'b0000};
    s_addr[0] = 11'h010; s_data[0] = 32'd12;
    s_addr[1] = 11'h005; s_data[1] = 32'h21524110;

    // ---- reset state ----
    clear_mems();
    @(posedge clk);
    @(negedge clk);
    chk("rst_imem_re",   {31'd0, imem_re}, 32'd0);
    chk("rst_imem_addr", {21'd0, imem_addr}, 32'd0);
    chk("rst_dmem_re",   {31'd0, dmem_re}, 32'd0);
    chk("rst_dmem_we",   {31'd0, dmem_we}, 32'd0);
    chk("rst_retire",    {31'd0, retire}, 32'd0);
    chk("rst_stall",     {31'd0, stall}, 32'd0);
    chk("rst_result",    result, 32'd0);
    chk("rst_flags",     {28'd0, flags}, 32'd0);

    // ---- table program ----
    for (int i = 0; i < NV; i++) imem[i] = vt[i].ins;
    dmem[3] = 32'hDEADBEEF;
    do_reset();
    idx = 0; nstall = 0; stall_cyc = -1; first_cyc = -1; last_cyc = -1; sidx = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall) begin
        nstall++;
        stall_cyc = c;
        chk("stall_imem_re", {31'd0, imem_re}, 32'd0);
      end
      if (dmem_we) begin
        if (sidx < 2) begin
          chk($sformatf("st%0d_addr", sidx), {21'd0, dmem_addr}, {21'd0, s_addr[sidx]});
          chk($sformatf("st%0d_data", sidx), dmem_wdata, s_data[sidx]);
        end
        sidx++;
      end
      if (retire && idx < NV) begin
        if (idx == 0) first_cyc = c;
        if (idx == NV - 1) last_cyc = c;
        chk($sformatf("vec%0d_result", idx), result, vt[idx].res);
        if (vt[idx].fchk) chk($sformatf("vec%0d_flags", idx), {28'd0, flags}, {28'd0, vt[idx].flg});
        idx++;
      end
    end
    chk("tbl_retired",     idx, NV);
    chk("tbl_first_retire", first_cyc, 4);
    chk("tbl_last_retire",  last_cyc, 23);
    chk("tbl_stall_cycles", nstall, 1);
    chk("tbl_stall_cycle",  stall_cyc, 11);
    chk("tbl_stores",       sidx, 2);

    // ---- branch: taken Z flushes two fetches, not-taken !Z costs nothing ----
    clear_mems();
    imem[0]     = enc(OP_ADD,    5'd1,        5'd0, 5'd0, 1'b1, 13'd5);
    imem[1]     = enc(OP_SUB,    5'd5,        5'd1, 5'd1, 1'b0, 13'd0);
    imem[2]     = enc(OP_BRANCH, {BC_Z, 2'b00}, 5'd0, 5'd0, 1'b0, 13'h020);
    imem[3]     = enc(OP_ADD,    5'd6,        5'd0, 5'd0, 1'b1, 13'd99);
    imem[4]     = enc(OP_ADD,    5'd6,        5'd0, 5'd0, 1'b1, 13'd98);
    imem[11'h20] = enc(OP_ADD,   5'd7,        5'd0, 5'd0, 1'b1, 13'h33);
    imem[11'h21] = enc(OP_SUB,   5'd8,        5'd1, 5'd1, 1'b0, 13'd0);
    imem[11'h22] = enc(OP_BRANCH, {BC_NZ, 2'b00}, 5'd0, 5'd0, 1'b0, 13'h030);
    imem[11'h23] = enc(OP_ADD,   5'd9,        5'd0, 5'd0, 1'b1, 13'h44);
    imem[11'h24] = enc(OP_ADD,   5'd10,       5'd0, 5'd0, 1'b1, 13'h55);
    bexp[0] = '{4, 32'd5};   bexp[1] = '{5, 32'd0};  bexp[2] = '{6, 32'd0};
    bexp[3] = '{9, 32'h33};  bexp[4] = '{10, 32'd0}; bexp[5] = '{11, 32'd0};
    bexp[6] = '{12, 32'h44}; bexp[7] = '{13, 32'h55};
    do_reset();
    bgot.delete();
    nstall = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 5) chk("br_target_addr", {21'd0, imem_addr}, 32'h020);
      if (stall) nstall++;
      if (retire) bgot.push_back('{c, result});
    end
    chk("br_retire_count", bgot.size(), 8);
    for (int i = 0; i < 8 && i < bgot.size(); i++) begin
      chk($sformatf("br%0d_cycle", i), bgot[i].cyc, bexp[i].cyc);
      chk($sformatf("br%0d_result", i), bgot[i].res, bexp[i].res);
    end
    chk("br_no_stall", nstall, 0);

    // ---- reset asserted during a load-use stall ----
    clear_mems();
    imem[0] = enc(OP_ADD,  5'd1, 5'd0, 5'd0, 1'b1, 13'd5);
    imem[1] = enc(OP_ADD,  5'd2, 5'd0, 5'd0, 1'b1, 13'd7);
    imem[2] = enc(OP_LOAD, 5'd3, 5'd0, 5'd0, 1'b1, 13'd3);
    imem[3] = enc(OP_ADD,  5'd4, 5'd3, 5'd0, 1'b1, 13'd1);
    do_reset();
    for (int c = 0; c < 5; c++) @(negedge clk);
    chk("rs_stall_before", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_stall_in_reset", {31'd0, stall}, 32'd0);
    chk("rs_retire_in_reset", {31'd0, retire}, 32'd0);
    @(negedge clk);
    chk("rs_pc_next", {21'd0, imem_addr}, 32'd0);
    chk("rs_imem_re", {31'd0, imem_re}, 32'd0);
    chk("rs_result", result, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    nz = 0;
    for (int i = 1; i < 32; i++) if (dut.u_rf.regs[i] != 32'd0) nz++;
    chk("rs_regs_zero", nz, 0);
    nret = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (retire) nret++;
    end
    chk("rs_no_retire_4", nret, 0);
    @(negedge clk);
    chk("rs_first_retire", {31'd0, retire}, 32'd1);
    chk("rs_first_result", result, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
